// File: rtl/knn_pkg.sv
// Shared constants and types for the KNN point loader.
// Default sizes, point word layout and loader FSM states.
package knn_pkg;

    localparam int WIDTH_DEF    = 4;
    localparam int TAG_DEF      = 2;
    localparam int MEM_SIZE_DEF = 1024;
    localparam int ADDR_W       = $clog2(MEM_SIZE_DEF);
    localparam int POINT_W      = TAG_DEF + 2 * WIDTH_DEF;

    typedef struct packed {
        logic [TAG_DEF-1:0]   tag;
        logic [WIDTH_DEF-1:0] x;
        logic [WIDTH_DEF-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_DONE
    } loader_state_e;

endpackage

// File: rtl/knn_point_mem.sv
// Point RAM: one write port, one synchronous read port (1-cycle latency).
// Ports: clk_i; we_i/waddr_i/wdata_i write; re_i/raddr_i read, rdata_o data.
module knn_point_mem
    import knn_pkg::*;
#(
    parameter int DEPTH = MEM_SIZE_DEF,
    parameter int W     = POINT_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/knn_point_loader.sv
// KNN point loader: stores labelled points, then on start presents the query
// and streams every point over valid/ready, finally capturing the class result.
// Ports: clk_i, rst_i (sync, active high); wr_v_i/wr_data_i/wr_ready_o host
// writes; clr_i, start_i, qx_i, qy_i, k_i, abort_i control; x1_o/y1_o/num_o/k_o
// query; x2_o/y2_o/valid_o/ready_i stream; done_i/class_i/class_o/class_v_o
// result; count_o, busy_o, err_o status.
// Optional: KNN_LOADER_STATS_EN adds stall_cnt_o (stalled STREAM cycles).
module knn_point_loader
    import knn_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int TAG      = TAG_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    localparam int AW      = $clog2(MEM_SIZE),
    localparam int PW      = TAG + 2 * WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_v_i,
    input  logic [PW-1:0]        wr_data_i,
    output logic                 wr_ready_o,
    input  logic                 clr_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     qx_i,
    input  logic [WIDTH-1:0]     qy_i,
    input  logic [AW-1:0]        k_i,
    input  logic                 abort_i,
    output logic [TAG+WIDTH-1:0] x1_o,
    output logic [TAG+WIDTH-1:0] y1_o,
    output logic [TAG+WIDTH-1:0] x2_o,
    output logic [TAG+WIDTH-1:0] y2_o,
    output logic [AW-1:0]        num_o,
    output logic [AW-1:0]        k_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    input  logic                 done_i,
    input  logic [TAG-1:0]       class_i,
    output logic [TAG-1:0]       class_o,
    output logic                 class_v_o,
    output logic [AW-1:0]        count_o,
    output logic                 busy_o,
`ifdef KNN_LOADER_STATS_EN
    output logic [15:0]          stall_cnt_o,
`endif
    output logic                 err_o
);

    localparam logic [AW-1:0] FULL = AW'(MEM_SIZE - 1);

    loader_state_e   state_q, state_d;
    logic [AW-1:0]   count_q, count_d, num_q, num_d, k_q, k_d;
    logic [AW-1:0]   rd_idx_q, rd_idx_d, tx_idx_q, tx_idx_d;
    logic [WIDTH-1:0] qx_q, qx_d, qy_q, qy_d;
    logic [PW-1:0]   sk0_q, sk0_d, sk1_q, sk1_d;
    logic [1:0]      sk_cnt_q, sk_cnt_d;
    logic            pend_q, pend_d;
    logic [TAG-1:0]  class_q, class_d;
    logic            class_v_q, class_v_d, err_q, err_d;
    logic            mem_re;
    logic [AW-1:0]   mem_raddr;
    logic [PW-1:0]   mem_rdata;
    logic [2:0]      occ;
    logic            idle, wr_fire, start_acc, pop;

    assign idle       = (state_q == IDLE);
    assign wr_ready_o = idle & (count_q != FULL) & ~start_i & ~clr_i & ~abort_i;
    assign wr_fire    = wr_v_i & wr_ready_o;
    assign start_acc  = idle & start_i & ~clr_i & ~abort_i
                      & (k_i != '0) & (k_i <= count_q);
    assign valid_o    = (state_q == STREAM) & (sk_cnt_q != 2'd0);
    assign pop        = valid_o & ready_i;
    // Skid slots held next cycle if nothing new is read; a read is only
    // issued when its data is guaranteed a free slot on arrival.
    assign occ        = {1'b0, sk_cnt_q} + {2'b0, pend_q} - {2'b0, pop};

    knn_point_mem #(.DEPTH(MEM_SIZE), .W(PW)) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_fire),
        .waddr_i (count_q),
        .wdata_i (wr_data_i),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        num_d     = num_q;
        k_d       = k_q;
        rd_idx_d  = rd_idx_q;
        tx_idx_d  = tx_idx_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        sk0_d     = sk0_q;
        sk1_d     = sk1_q;
        sk_cnt_d  = sk_cnt_q;
        pend_d    = pend_q;
        class_d   = class_q;
        class_v_d = 1'b0;
        err_d     = 1'b0;
        mem_re    = 1'b0;
        mem_raddr = rd_idx_q;
        if (abort_i) begin
            state_d  = IDLE;
            sk_cnt_d = 2'd0;
            pend_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        count_d = '0;
                    end else if (start_i) begin
                        if (start_acc) begin
                            // Fetch point 0 now so it lands in the skid
                            // one cycle into STREAM.
                            mem_re    = 1'b1;
                            mem_raddr = '0;
                            rd_idx_d  = AW'(1);
                            tx_idx_d  = '0;
                            pend_d    = 1'b1;
                            sk_cnt_d  = 2'd0;
                            qx_d      = qx_i;
                            qy_d      = qy_i;
                            num_d     = count_q;
                            k_d       = k_i;
                            state_d   = STREAM;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (wr_fire) begin
                        count_d = count_q + 1'b1;
                    end
                end
                STREAM: begin
                    unique case ({pend_q, pop})
                        2'b10: begin
                            if (sk_cnt_q == 2'd0) sk0_d = mem_rdata;
                            else sk1_d = mem_rdata;
                            sk_cnt_d = sk_cnt_q + 2'd1;
                        end
                        2'b01: begin
                            sk0_d    = sk1_q;
                            sk_cnt_d = sk_cnt_q - 2'd1;
                        end
                        2'b11: begin
                            if (sk_cnt_q == 2'd1) begin
                                sk0_d = mem_rdata;
                            end else begin
                                sk0_d = sk1_q;
                                sk1_d = mem_rdata;
                            end
                        end
                        default: ;
                    endcase
                    pend_d = 1'b0;
                    if (rd_idx_q != num_q && occ <= 3'd1) begin
                        mem_re   = 1'b1;
                        pend_d   = 1'b1;
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                    if (pop) begin
                        tx_idx_d = tx_idx_q + 1'b1;
                        if (tx_idx_q == num_q - 1'b1) state_d = WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        class_d   = class_i;
                        class_v_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            num_q     <= '0;
            k_q       <= '0;
            rd_idx_q  <= '0;
            tx_idx_q  <= '0;
            qx_q      <= '0;
            qy_q      <= '0;
            sk0_q     <= '0;
            sk1_q     <= '0;
            sk_cnt_q  <= 2'd0;
            pend_q    <= 1'b0;
            class_q   <= '0;
            class_v_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            num_q     <= num_d;
            k_q       <= k_d;
            rd_idx_q  <= rd_idx_d;
            tx_idx_q  <= tx_idx_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            sk0_q     <= sk0_d;
            sk1_q     <= sk1_d;
            sk_cnt_q  <= sk_cnt_d;
            pend_q    <= pend_d;
            class_q   <= class_d;
            class_v_q <= class_v_d;
            err_q     <= err_d;
        end
    end

`ifdef KNN_LOADER_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc) stall_d = '0;
        else if (valid_o & ~ready_i & (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_q <= '0;
        else stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`endif

    assign x1_o      = {{TAG{1'b0}}, qx_q};
    assign y1_o      = {{TAG{1'b0}}, qy_q};
    assign x2_o      = {sk0_q[PW-1 -: TAG], sk0_q[2*WIDTH-1 -: WIDTH]};
    assign y2_o      = {sk0_q[PW-1 -: TAG], sk0_q[WIDTH-1:0]};
    assign num_o     = num_q;
    assign k_o       = k_q;
    assign class_o   = class_q;
    assign class_v_o = class_v_q;
    assign count_o   = count_q;
    assign busy_o    = ~idle;
    assign err_o     = err_q;

endmodule

// File: tb/tb_knn_point_loader.sv
// Testbench for knn_point_loader: random points and handshake patterns
// checked against a queue-style model of stored points and expected beats.
module tb_knn_point_loader;
    import knn_pkg::*;

    localparam int AW  = ADDR_W;
    localparam int PW  = POINT_W;
    localparam int CW  = TAG_DEF + WIDTH_DEF;
    localparam int CAP = MEM_SIZE_DEF - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, wr_v, clr, start, abort_s, ready, done;
    logic [PW-1:0]        wr_data;
    logic [WIDTH_DEF-1:0] qx, qy;
    logic [AW-1:0]        k;
    logic [TAG_DEF-1:0]   cls_in;
    logic                 wr_ready_o, valid_o, class_v_o, busy_o, err_o;
    logic [CW-1:0]        x1_o, y1_o, x2_o, y2_o;
    logic [AW-1:0]        num_o, k_o, count_o;
    logic [TAG_DEF-1:0]   class_o;
`ifdef KNN_LOADER_STATS_EN
    logic [15:0]          stall_cnt_o;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [PW-1:0]      ref_pts [CAP];
    int                 ref_count = 0;
    logic [TAG_DEF-1:0] ref_class = '0;

    knn_point_loader dut (
        .clk_i(clk), .rst_i(rst), .wr_v_i(wr_v), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready_o), .clr_i(clr), .start_i(start),
        .qx_i(qx), .qy_i(qy), .k_i(k), .abort_i(abort_s),
        .x1_o(x1_o), .y1_o(y1_o), .x2_o(x2_o), .y2_o(y2_o),
        .num_o(num_o), .k_o(k_o), .valid_o(valid_o), .ready_i(ready),
        .done_i(done), .class_i(cls_in), .class_o(class_o),
        .class_v_o(class_v_o), .count_o(count_o), .busy_o(busy_o),
`ifdef KNN_LOADER_STATS_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .err_o(err_o)
    );

    function automatic logic [CW-1:0] exp_x(input logic [PW-1:0] w);
        point_t p;
        p = w;
        return {p.tag, p.x};
    endfunction

    function automatic logic [CW-1:0] exp_y(input logic [PW-1:0] w);
        point_t p;
        p = w;
        return {p.tag, p.y};
    endfunction

    task automatic write_word(input logic [PW-1:0] d);
        logic acc;
        wr_v = 1'b1;
        wr_data = d;
        #1;
        acc = (ref_count < CAP);
        vectors++;
        if (wr_ready_o !== acc) begin
            miscompares++;
            $display("FAIL wr_ready got %b want %b (count %0d)", wr_ready_o, acc, ref_count);
        end
        @(negedge clk);
        wr_v = 1'b0;
        if (acc) begin
            ref_pts[ref_count] = d;
            ref_count++;
        end
    endtask

    task automatic write_points(input int n);
        for (int i = 0; i < n; i++) write_word(PW'($urandom));
        vectors++;
        if (count_o !== AW'(ref_count)) begin
            miscompares++;
            $display("FAIL count_after_write got %0d want %0d", count_o, ref_count);
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ref_count = 0;
    endtask

    // mode 0: ready always high, 1: toggling, 2: random
    task automatic run_query(input logic [AW-1:0] kk, input int mode,
                             input logic [TAG_DEF-1:0] cls);
        int beats, cyc, gaps, stalls;
        logic prev_stall, rdy;
        logic [CW-1:0] px2, py2;
        logic [WIDTH_DEF-1:0] ex, ey;
        ex = WIDTH_DEF'($urandom);
        ey = WIDTH_DEF'($urandom);
        start = 1'b1; k = kk; qx = ex; qy = ey; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL start_plus1 valid=%b busy=%b want 0/1", valid_o, busy_o);
        end
        vectors++;
        if (num_o !== AW'(ref_count) || k_o !== kk
            || x1_o !== {{TAG_DEF{1'b0}}, ex} || y1_o !== {{TAG_DEF{1'b0}}, ey}) begin
            miscompares++;
            $display("FAIL query_latch num=%0d k=%0d x1=%h y1=%h want %0d %0d %h %h",
                     num_o, k_o, x1_o, y1_o, ref_count, kk, ex, ey);
        end
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL first_valid got %b want 1", valid_o);
        end
        beats = 0; cyc = 0; gaps = 0; stalls = 0;
        prev_stall = 1'b0; px2 = '0; py2 = '0;
        while (beats < ref_count && cyc < 8 * CAP + 16) begin
            if (prev_stall) begin
                vectors++;
                if (valid_o !== 1'b1 || x2_o !== px2 || y2_o !== py2) begin
                    miscompares++;
                    $display("FAIL stall_hold valid=%b x2=%h y2=%h want 1 %h %h",
                             valid_o, x2_o, y2_o, px2, py2);
                end
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ~ready;
            else rdy = 1'($urandom_range(0, 1));
            ready = rdy;
            if (valid_o === 1'b1 && rdy) begin
                vectors++;
                if (x2_o !== exp_x(ref_pts[beats]) || y2_o !== exp_y(ref_pts[beats])) begin
                    miscompares++;
                    $display("FAIL beat%0d x2=%h y2=%h want %h %h", beats, x2_o, y2_o,
                             exp_x(ref_pts[beats]), exp_y(ref_pts[beats]));
                end
                beats++;
            end
            if (valid_o !== 1'b1) gaps++;
            if (valid_o === 1'b1 && !rdy) stalls++;
            prev_stall = (valid_o === 1'b1) && !rdy;
            px2 = x2_o;
            py2 = y2_o;
            @(negedge clk);
            cyc++;
        end
        ready = 1'b1;
        vectors++;
        if (beats != ref_count) begin
            miscompares++;
            $display("FAIL stream_timeout beats=%0d want %0d", beats, ref_count);
        end
        if (mode == 0) begin
            vectors++;
            if (gaps != 0) begin
                miscompares++;
                $display("FAIL back_to_back gaps=%0d want 0", gaps);
            end
        end
`ifdef KNN_LOADER_STATS_EN
        vectors++;
        if (stall_cnt_o !== 16'(stalls)) begin
            miscompares++;
            $display("FAIL stall_cnt got %0d want %0d", stall_cnt_o, stalls);
        end
`endif
        vectors++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL after_last valid=%b busy=%b want 0/1", valid_o, busy_o);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        vectors++;
        if (count_o !== AW'(ref_count)) begin
            miscompares++;
            $display("FAIL clr_ignored count=%0d want %0d", count_o, ref_count);
        end
        done = 1'b1;
        cls_in = cls;
        @(negedge clk);
        done = 1'b0;
        ref_class = cls;
        vectors++;
        if (class_v_o !== 1'b1 || class_o !== cls || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL capture class_v=%b class=%0d busy=%b want 1 %0d 0",
                     class_v_o, class_o, busy_o, cls);
        end
        @(negedge clk);
        vectors++;
        if (class_v_o !== 1'b0 || class_o !== cls) begin
            miscompares++;
            $display("FAIL class_hold class_v=%b class=%0d want 0 %0d", class_v_o, class_o, cls);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || class_v_o !== 1'b0
            || count_o !== '0 || num_o !== '0 || k_o !== '0 || class_o !== '0
            || x1_o !== '0 || y1_o !== '0 || x2_o !== '0 || y2_o !== '0) begin
            miscompares++;
            $display("FAIL reset_state valid=%b busy=%b count=%0d num=%0d x2=%h want all 0",
                     valid_o, busy_o, count_o, num_o, x2_o);
        end
        ref_count = 0;
        ref_class = '0;
    endtask

    task automatic write_fixed_set();
        do_clear();
        write_word({2'd1, 4'd3, 4'd4});
        write_word({2'd2, 4'd0, 4'd0});
        write_word({2'd1, 4'd9, 4'd9});
        vectors++;
        if (count_o !== AW'(3)) begin
            miscompares++;
            $display("FAIL fixed_count got %0d want 3", count_o);
        end
    endtask

    task automatic test_basic();
        write_fixed_set();
        run_query(AW'(1), 0, 2'd2);
    endtask

    task automatic test_stall();
        run_query(AW'(3), 1, 2'd1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int n;
            do_clear();
            n = $urandom_range(1, 40);
            write_points(n);
            run_query(AW'($urandom_range(1, n)), 2, TAG_DEF'($urandom));
        end
    endtask

    task automatic test_errors();
        do_clear();
        start = 1'b1; k = AW'(1);
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_empty err=%b busy=%b valid=%b want 1 0 0", err_o, busy_o, valid_o);
        end
        @(negedge clk);
        vectors++;
        if (err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse got %b want 0", err_o);
        end
        write_points(3);
        start = 1'b1; k = AW'(4); wr_v = 1'b1; wr_data = PW'($urandom);
        #1;
        vectors++;
        if (wr_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL start_blocks_write wr_ready=%b want 0", wr_ready_o);
        end
        @(negedge clk);
        start = 1'b0; wr_v = 1'b0;
        vectors++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || count_o !== AW'(3)) begin
            miscompares++;
            $display("FAIL err_k_gt err=%b busy=%b count=%0d want 1 0 3", err_o, busy_o, count_o);
        end
        start = 1'b1; k = '0;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_k0 err=%b busy=%b want 1 0", err_o, busy_o);
        end
        done = 1'b1; cls_in = ~ref_class;
        @(negedge clk);
        done = 1'b0;
        vectors++;
        if (class_v_o !== 1'b0 || class_o !== ref_class || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL done_idle class_v=%b class=%0d want 0 %0d", class_v_o, class_o, ref_class);
        end
    endtask

    task automatic test_abort();
        write_fixed_set();
        start = 1'b1; k = AW'(2); ready = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        vectors++;
        if (valid_o !== 1'b1 || x2_o !== exp_x(ref_pts[1])) begin
            miscompares++;
            $display("FAIL abort_beat2 valid=%b x2=%h want 1 %h", valid_o, x2_o, exp_x(ref_pts[1]));
        end
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || count_o !== AW'(3) || class_o !== ref_class) begin
            miscompares++;
            $display("FAIL abort valid=%b busy=%b count=%0d class=%0d want 0 0 3 %0d",
                     valid_o, busy_o, count_o, class_o, ref_class);
        end
        run_query(AW'(3), 0, 2'd3);
    endtask

    task automatic test_full();
        do_clear();
        write_points(CAP);
        write_points(1);
        vectors++;
        if (count_o !== AW'(CAP) || wr_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full count=%0d wr_ready=%b want %0d 0", count_o, wr_ready_o, CAP);
        end
        run_query(AW'($urandom_range(1, CAP)), 2, TAG_DEF'($urandom));
    endtask

    task automatic test_reset_mid();
        write_points(5);
        start = 1'b1; k = AW'(1); ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        ref_count = 0;
        ref_class = '0;
        vectors++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || count_o !== '0 || class_o !== '0 || x1_o !== '0) begin
            miscompares++;
            $display("FAIL reset_mid valid=%b busy=%b count=%0d want 0 0 0", valid_o, busy_o, count_o);
        end
    endtask

    initial begin
        rst = 1'b1; wr_v = 1'b0; clr = 1'b0; start = 1'b0; abort_s = 1'b0;
        ready = 1'b1; done = 1'b0; wr_data = '0; qx = '0; qy = '0; k = '0; cls_in = '0;
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_errors();
        test_abort();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
